// File: rtl/button_conditioner_if.sv
// Bundled pushbutton signals between the board inputs, button_conditioner
// and the instruction decoder that consumes its command strobes.
interface button_conditioner_if;
    logic [5:0] btn_raw;
    logic [5:0] btn_level;
    logic [5:0] btn_pulse;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       any_held;

    modport master (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output cmd_valid,
        output cmd_code,
        output any_held
    );

    modport slave (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  cmd_valid,
        input  cmd_code,
        input  any_held
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronise, debounce, edge-detect and priority-encode six calculator buttons.
// Define BTN_LOCKOUT_EN to allow only one command per gesture (IDLE/LOCKED FSM).
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                reset,
    button_conditioner_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [5:0]       s1;
    logic [5:0]       s2;
    logic [5:0]       level;
    logic [5:0]       level_d;
    logic [5:0]       rise;
    logic [5:0]       grant;
    logic [5:0]       pulse_q;
    logic             valid_q;
    logic [2:0]       code_q;
    logic [2:0]       code_n;
    logic             allow;
    logic [CNT_W-1:0] cnt [6];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.btn_raw;
            s2 <= s1;
        end
    end

    // Any agreement between the synchronised input and the accepted level
    // restarts the count, so only an unbroken run of disagreement flips it.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= '0;
            for (int i = 0; i < 6; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (s2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= s2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_d <= '0;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;

    // Lowest index wins; losing rises are dropped rather than queued.
    always_comb begin
        grant  = '0;
        code_n = '0;
        for (int i = 0; i < 6; i++) begin
            if (allow && rise[i] && (grant == 6'b0)) begin
                grant[i] = 1'b1;
                code_n   = 3'(i + 1);
            end
        end
    end

`ifdef BTN_LOCKOUT_EN
    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t state;
    state_t state_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    assign allow = (state == IDLE);

    // Stay locked until every button is released, so chords and rolls
    // produce a single command.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (grant != 6'b0) begin
                    state_n = LOCKED;
                end
            end
            LOCKED: begin
                if (level == 6'b0) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
`else
    assign allow = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_q <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
        end else begin
            pulse_q <= grant;
            valid_q <= (grant != 6'b0);
            code_q  <= code_n;
        end
    end

    assign bus.btn_level = level;
    assign bus.btn_pulse = pulse_q;
    assign bus.cmd_valid = valid_q;
    assign bus.cmd_code  = code_q;
    assign bus.any_held  = |level;

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end for the calculator's six pushbuttons (add, sub, mult, div, prev, write_en). It synchronises each raw switch input, debounces it, and detects the press edge. It then resolves simultaneous presses by fixed priority and emits one single-cycle command pulse plus a 3-bit command code. It sits directly upstream of the instruction decoder, which receives clean one-cycle button strobes instead of raw board inputs.

## Interface
- DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal minimum 2
- CNT_W, default 20, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- btn_raw  in  6  asynchronous buttons: [0] add, [1] sub, [2] mult, [3] div, [4] prev, [5] write_en
- btn_level  out  6  debounced button levels
- btn_pulse  out  6  one-cycle press strobes, at most one bit set, same bit order as btn_raw
- cmd_valid  out  1  high exactly when btn_pulse != 0
- cmd_code  out  3  accepted command: 001 add, 010 sub, 011 mult, 100 div, 101 prev, 110 write_en; 000 when cmd_valid = 0
- any_held  out  1  OR of btn_level

## Operation
- Synchroniser: two flip-flops per bit (s1, s2), reset 0.
- Debounce, per bit: counter cnt[CNT_W-1:0].
  - When s2 == btn_level: cnt <= 0.
  - When s2 != btn_level and cnt == DEBOUNCE_CYCLES-1: btn_level <= s2 and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - A disagreement shorter than DEBOUNCE_CYCLES cycles leaves btn_level unchanged and restarts the count.
- Edge detect: rise[i] = btn_level[i] went 0->1 on the previous edge (registered copy of btn_level compared with current value).
- Priority: when several rise bits are set in one cycle, the lowest index wins. Others are discarded, not queued.
- btn_pulse, cmd_valid and cmd_code are registered outputs, valid for exactly one cycle per accepted press.
- Releases (1->0) never produce pulses.
- Reset: s1, s2, cnt, btn_level, btn_pulse, cmd_valid, cmd_code, any_held and FSM state all go to 0/IDLE on the edge where reset is sampled high.
- A button held through reset deassertion is treated as a new press: it produces a pulse after the normal debounce latency.
- Reset asserted mid-debounce aborts the count with no pulse.

## Timing
- Edge 0 is the first edge sampling btn_raw[i] high; input held steady thereafter.
  - btn_level[i] is high after edge DEBOUNCE_CYCLES+1.
  - btn_pulse[i], cmd_valid and cmd_code are valid after edge DEBOUNCE_CYCLES+2, for one cycle.
- Release latency to btn_level low: DEBOUNCE_CYCLES+1 edges, symmetric with press.
- Back-to-back presses of different buttons produce pulses in separate cycles. No minimum gap beyond debounce.
- No backpressure: the consumer must sample every cmd_valid cycle.

## Configuration
- Macro BTN_LOCKOUT_EN.
- Defined: two-state FSM.
  - IDLE: an accepted pulse moves the FSM to LOCKED.
  - LOCKED: all rises are suppressed (no pulses). The FSM returns to IDLE on the first cycle with btn_level == 0, and a rise in that same cycle is still suppressed.
  - Effect: one command per gesture, even with chorded or rolled presses.
- Undefined: no FSM. Every debounced rise is eligible for a pulse, subject only to priority.

## Test plan
- DEBOUNCE_CYCLES=4, reset 3 cycles, then btn_raw=000001 held -> btn_level[0]=1 after edge 5; btn_pulse=000001, cmd_valid=1, cmd_code=001 for exactly one cycle after edge 6; outputs 0 during and right after reset.
- btn_raw[3] high for 3 cycles then low (bounce) -> btn_level stays 000000, no cmd_valid; then held 10 cycles -> single pulse, cmd_code=100.
- btn_raw=001001 rising on the same edge -> one pulse, btn_pulse=000001, cmd_code=001; div press lost; releasing both gives no pulse.
- Press prev, release, press write_en (each held 8 cycles, DEBOUNCE_CYCLES=4) -> two pulses, codes 101 then 110; any_held tracks btn_level.
- BTN_LOCKOUT_EN defined: hold sub, then press mult while sub held -> only code 010; release all, press mult -> code 011. Undefined: same stimulus gives 010, 011, 011.
- Reset asserted at count 2 of a mult debounce, released with button still held -> no pulse during reset; pulse code 011 DEBOUNCE_CYCLES+2 edges after release.
